// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback stage for the b-risc integer register file.
// Accepts load and ALU results over valid/ready handshakes. Each accepted
// result goes into a small in-order circular queue. The stage retires at most
// one register-file write per clock and offers a bypass lookup of results that
// are still pending.
//
// Ports:
//   clk, aresetn              clock; asynchronous active-low reset
//   mem_valid/ready/reg/data  load-unit result handshake (higher priority)
//   alu_valid/ready/reg/data  ALU result handshake
//   hold                      freeze draining; the queue still accepts
//   wr_en/wr_reg/wr_data      registered register-file write port
//   q_reg -> q_hit/q_data     combinational bypass lookup
//   count                     current queue occupancy
//
// Build option: define WB_BYPASS_EN to build the bypass search. Without it,
// q_hit and q_data are tied to 0.
module regfile_writeback #(
    parameter int unsigned REG_W     = 32,
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_IDX_W-1:0]     mem_reg,
    input  logic [REG_W-1:0]         mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_IDX_W-1:0]     alu_reg,
    input  logic [REG_W-1:0]         alu_data,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [REG_IDX_W-1:0]     wr_reg,
    output logic [REG_W-1:0]         wr_data,
    input  logic [REG_IDX_W-1:0]     q_reg,
    output logic                     q_hit,
    output logic [REG_W-1:0]         q_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [REG_W-1:0]     data;
    } entry_t;

    entry_t               fifo_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wr_en_q, wr_en_d;
    logic [REG_IDX_W-1:0] wr_reg_q, wr_reg_d;
    logic [REG_W-1:0]     wr_data_q, wr_data_d;

    logic                 not_full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;

    // Readiness looks only at occupancy, so a same-cycle pop never frees a slot.
    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;

    // Producer select: the load result is older, so it wins.
    always_comb begin
        push_entry = '{rd: alu_reg, data: alu_data};
        accept     = alu_valid && alu_ready;
        if (mem_valid && mem_ready) begin
            push_entry = '{rd: mem_reg, data: mem_data};
            accept     = 1'b1;
        end
    end

    // Writes to r0 complete the handshake but are dropped.
    assign push = accept && (push_entry.rd != '0);
    assign pop  = (count_q != '0) && !hold;

    // Next-state for pointers, occupancy and the output write register.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = pop;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            head_d    = head_q + PTR_W'(1);
            wr_reg_d  = fifo_q[head_q].rd;
            wr_data_d = fifo_q[head_q].data;
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Queue storage; validity is tracked by head/count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= push_entry;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;

`ifdef WB_BYPASS_EN
    // Bypass search: the output register is the lowest priority, then queue
    // entries from oldest to youngest, so the youngest match is the one that
    // lands in q_data.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (wr_en_q && (wr_reg_q == q_reg)) begin
            q_hit  = 1'b1;
            q_data = wr_data_q;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (fifo_q[head_q + PTR_W'(k)].rd == q_reg)) begin
                q_hit  = 1'b1;
                q_data = fifo_q[head_q + PTR_W'(k)].data;
            end
        end
        if (q_reg == '0) begin
            q_hit  = 1'b0;
            q_data = '0;
        end
    end
`else
    logic unused_q_reg;
    assign unused_q_reg = ^q_reg;
    assign q_hit        = 1'b0;
    assign q_data       = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed bench for regfile_writeback. A queue-based
// model predicts the write port, occupancy, readiness and bypass result, and
// these are compared against the DUT on every falling edge. Literal
// expectations pin the model to the documented scenarios.
module tb_regfile_writeback;

    localparam int unsigned REG_W     = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DEPTH     = 4;

    logic                   clk;
    logic                   aresetn;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [REG_IDX_W-1:0]   mem_reg;
    logic [REG_W-1:0]       mem_data;
    logic                   alu_valid;
    logic                   alu_ready;
    logic [REG_IDX_W-1:0]   alu_reg;
    logic [REG_W-1:0]       alu_data;
    logic                   hold;
    logic                   wr_en;
    logic [REG_IDX_W-1:0]   wr_reg;
    logic [REG_W-1:0]       wr_data;
    logic [REG_IDX_W-1:0]   q_reg;
    logic                   q_hit;
    logic [REG_W-1:0]       q_data;
    logic [$clog2(DEPTH):0] count;

    regfile_writeback #(
        .REG_W    (REG_W),
        .REG_IDX_W(REG_IDX_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_reg  (mem_reg),
        .mem_data (mem_data),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_reg  (alu_reg),
        .alu_data (alu_data),
        .hold     (hold),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .q_reg    (q_reg),
        .q_hit    (q_hit),
        .q_data   (q_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Register file seen by the write port.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (aresetn && wr_en) rf[wr_reg] <= wr_data;
    end

    // Behavioural model: a plain queue of pending writes plus the expected port.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [$];
    logic        exp_wr_en;
    logic [4:0]  exp_wr_reg;
    logic [31:0] exp_wr_data;

    always @(posedge clk or negedge aresetn) begin
        int   n;
        ent_t e;
        bit   take;
        if (!aresetn) begin
            mq.delete();
            exp_wr_en   = 1'b0;
            exp_wr_reg  = '0;
            exp_wr_data = '0;
        end else begin
            n    = mq.size();
            take = 1'b0;
            e    = '0;
            if (n != DEPTH) begin
                if (mem_valid) begin
                    take = 1'b1;
                    e    = '{rd: mem_reg, data: mem_data};
                end else if (alu_valid) begin
                    take = 1'b1;
                    e    = '{rd: alu_reg, data: alu_data};
                end
            end
            if (n > 0 && !hold) begin
                exp_wr_en   = 1'b1;
                exp_wr_reg  = mq[0].rd;
                exp_wr_data = mq[0].data;
                void'(mq.pop_front());
            end else begin
                exp_wr_en = 1'b0;
            end
            if (take && e.rd != 5'd0) mq.push_back(e);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic        ehit;
        logic [31:0] edata;
        check("wr_en",     32'(wr_en),     32'(exp_wr_en));
        check("wr_reg",    32'(wr_reg),    32'(exp_wr_reg));
        check("wr_data",   wr_data,        exp_wr_data);
        check("count",     32'(count),     32'(mq.size()));
        check("mem_ready", 32'(mem_ready), 32'(mq.size() != DEPTH));
        check("alu_ready", 32'(alu_ready), 32'((mq.size() != DEPTH) && !mem_valid));
        ehit  = 1'b0;
        edata = '0;
`ifdef WB_BYPASS_EN
        if (q_reg != 5'd0) begin
            if (exp_wr_en && exp_wr_reg == q_reg) begin
                ehit  = 1'b1;
                edata = exp_wr_data;
            end
            foreach (mq[i]) begin
                if (mq[i].rd == q_reg) begin
                    ehit  = 1'b1;
                    edata = mq[i].data;
                end
            end
        end
`endif
        check("q_hit", 32'(q_hit), 32'(ehit));
        if (ehit) check("q_data", q_data, edata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] r, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic drive_mem(input logic [4:0] r, input logic [31:0] d);
        mem_valid = 1'b1;
        mem_reg   = r;
        mem_data  = d;
    endtask

    initial begin
        aresetn   = 1'b0;
        mem_valid = 1'b0;
        mem_reg   = '0;
        mem_data  = '0;
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        hold      = 1'b0;
        q_reg     = '0;

        // Reset state and immediate readiness.
        #1;
        check("rst_wr_en",     32'(wr_en),     32'd0);
        check("rst_wr_reg",    32'(wr_reg),    32'd0);
        check("rst_wr_data",   wr_data,        32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        mem_valid = 1'b1;
        #1;
        check("rst_alu_ready_memv", 32'(alu_ready), 32'd0);
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Single ALU result, latency of one edge to the write port.
        drive_alu(5'd5, 32'hDEADBEEF);
        tick();
        alu_valid = 1'b0;
        #1;
        check("t1_not_yet", 32'(wr_en), 32'd0);
        tick(); #1;
        check("t1_wr_en",   32'(wr_en),  32'd1);
        check("t1_wr_reg",  32'(wr_reg), 32'd5);
        check("t1_wr_data", wr_data,     32'hDEADBEEF);
        tick(); #1;
        check("t1_wr_en_off", 32'(wr_en), 32'd0);
        check("t1_rf5",       rf[5],      32'hDEADBEEF);

        // Load has priority over ALU.
        drive_mem(5'd3, 32'h11);
        drive_alu(5'd4, 32'h22);
        #1;
        check("t2_alu_ready", 32'(alu_ready), 32'd0);
        check("t2_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        #1;
        check("t2_alu_ready_after", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        #1;
        check("t2_first_reg",  32'(wr_reg), 32'd3);
        check("t2_first_data", wr_data,     32'h11);
        tick(); #1;
        check("t2_second_reg",  32'(wr_reg), 32'd4);
        check("t2_second_data", wr_data,     32'h22);
        tick(); #1;
        check("t2_idle", 32'(wr_en), 32'd0);

        // Fill under hold, stall a fifth, then drain in order.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_alu(5'(i), 32'h100 + 32'(i));
            tick();
        end
        drive_alu(5'd6, 32'h600);
        #1;
        check("t3_count_full", 32'(count),     32'd4);
        check("t3_mem_ready",  32'(mem_ready), 32'd0);
        check("t3_alu_ready",  32'(alu_ready), 32'd0);
        tick(); #1;
        check("t3_stalled", 32'(count), 32'd4);
        check("t3_hold_wr", 32'(wr_en), 32'd0);
        alu_valid = 1'b0;
        hold      = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            check("t3_drain_en",   32'(wr_en),  32'd1);
            check("t3_drain_reg",  32'(wr_reg), 32'(i));
            check("t3_drain_data", wr_data,     32'h100 + 32'(i));
        end
        tick(); #1;
        check("t3_drain_done", 32'(wr_en), 32'd0);

        // r0 results are discarded.
        hold = 1'b1;
        drive_alu(5'd0, 32'hFFFF);
        tick();
        drive_alu(5'd7, 32'h1);
        tick();
        drive_alu(5'd0, 32'hFFFF);
        tick();
        alu_valid = 1'b0;
        #1;
        check("t4_count", 32'(count), 32'd1);
        hold = 1'b0;
        tick(); #1;
        check("t4_wr_reg",  32'(wr_reg), 32'd7);
        check("t4_wr_data", wr_data,     32'h1);
        tick(); #1;
        check("t4_idle", 32'(wr_en), 32'd0);
        check("t4_rf7",  rf[7],      32'h1);

        // Bypass: youngest entry wins; r0 never hits.
        hold = 1'b1;
        drive_alu(5'd9, 32'hA);
        tick();
        drive_alu(5'd9, 32'hB);
        tick();
        alu_valid = 1'b0;
        q_reg     = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        check("t5_hit",  32'(q_hit), 32'd1);
        check("t5_data", q_data,     32'hB);
`else
        check("t5_hit_off", 32'(q_hit), 32'd0);
`endif
        q_reg = 5'd0;
        #1;
        check("t5_r0_hit", 32'(q_hit), 32'd0);
        q_reg = 5'd7;
        #1;
        check("t5_miss", 32'(q_hit), 32'd0);
        q_reg = 5'd9;
        hold  = 1'b0;
        repeat (3) tick();
        q_reg = 5'd0;

        // Reset mid-operation discards the queue and stops writes.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'(10 + i), 32'hC0 + 32'(i));
            tick();
        end
        alu_valid = 1'b0;
        hold      = 1'b0;
        tick(); #1;
        check("t6_pre_wr_en", 32'(wr_en), 32'd1);
        check("t6_pre_count", 32'(count), 32'd2);
        aresetn = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t6_no_write", 32'(wr_en), 32'd0);
        end

        // Back-to-back traffic from both producers with a mid-burst hold.
        for (int i = 0; i < 8; i++) begin
            drive_alu(5'(20 + i), 32'h5000 + 32'(i));
            if (i == 2 || i == 3) drive_mem(5'(28 + i), 32'h7000 + 32'(i));
            else                  mem_valid = 1'b0;
            hold = (i == 5);
            tick();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        hold      = 1'b0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage for the b-risc pipeline; drives the integer register file's single write port (wr_en/wr_reg/wr_data). It accepts results from the ALU and from the load unit over valid/ready handshakes and buffers them in a small in-order queue. It retires at most one write per clock and exposes a bypass lookup of not-yet-committed results to the decode stage.

## Interface
- REG_W, 32, data width of a register
- REG_IDX_W, 5, register index width
- DEPTH, 4, queue entries; power of two, ≥2

- clk  in  1  clock; all state on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted when valid&ready
- mem_reg  in  REG_IDX_W  load destination
- mem_data  in  REG_W  load data
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted when valid&ready
- alu_reg  in  REG_IDX_W  ALU destination
- alu_data  in  REG_W  ALU data
- hold  in  1  freeze draining; queue still accepts
- wr_en  out  1  register-file write enable, registered
- wr_reg  out  REG_IDX_W  register-file write index, registered
- wr_data  out  REG_W  register-file write data, registered
- q_reg  in  REG_IDX_W  bypass query index
- q_hit  out  1  pending write to q_reg exists, combinational
- q_data  out  REG_W  youngest pending data for q_reg
- count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- Queue is a circular buffer with head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH) plus an occupancy counter.
- mem_ready = (count != DEPTH).
- alu_ready = (count != DEPTH) && !mem_valid. Fixed priority goes to the load unit, whose instruction is older.
- At most one push per cycle.
- The ready signals depend only on count. No push-through when full, even if a pop happens in the same cycle.
- Accepted result with destination 0 completes the handshake but is discarded: no push, count unchanged.
- Drain: when count>0 and !hold, the head entry is popped. On that edge wr_en<=1, wr_reg<=head.reg, wr_data<=head.data.
- If no pop occurs on an edge, wr_en<=0. wr_reg and wr_data hold their previous values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Ordering: writes reach the register file in acceptance order. Two pending writes to the same register are both committed, oldest first.
- Bypass: q_hit=1 if any valid queue entry, or the output register while wr_en=1, targets q_reg.
- q_data priority: youngest queue entry first, then the output register.
- q_reg==0 always gives q_hit=0.
- The bypass search is combinational; results are not registered.

## Timing
- Reset: count=0, head=tail=0, wr_en=0, wr_reg=0, wr_data=0. mem_ready=1, and alu_ready=!mem_valid, immediately.
- Reset mid-operation discards all queued entries. No write is issued after aresetn falls.
- Latency: result accepted at edge k is earliest written at edge k+1 (wr_en high during cycle k+1→k+2). The register file captures it at edge k+2.
- Throughput: one write per cycle sustained while !hold.
- hold asserted: wr_en deasserts at the next edge, and queue contents are retained.
- Full: with count==DEPTH, no producer is ready. Space reopens the cycle after a pop.
- Empty: count==0 with !hold drives wr_en 0 next edge.

## Configuration
- WB_BYPASS_EN defined: the bypass lookup is implemented as described in Operation.
- WB_BYPASS_EN undefined: the search logic is not built. q_hit is tied to 0 and q_data to 0.
- Queue, handshake and write behaviour are identical with or without WB_BYPASS_EN.

## Test plan
- Reset, then a single ALU result r5=0xDEADBEEF accepted at edge 1 → wr_en=1, wr_reg=5, wr_data=0xDEADBEEF during cycle 2 only. The register file reads 0xDEADBEEF afterwards.
- mem_valid and alu_valid both high with r3=0x11 (mem) and r4=0x22 (alu) → alu_ready=0. The mem result is written first; the alu result is accepted the next cycle and written one cycle later.
- hold=1 with 4 ALU results pushed → count=4 and both ready signals 0, a 5th result is stalled. Releasing hold gives 4 consecutive writes in order, then wr_en=0.
- Results to r0 with data 0xFFFF interleaved with r7=0x1 → only r7 written; count never counts the r0 results.
- With WB_BYPASS_EN and hold=1, push r9=0xA then r9=0xB, query q_reg=9 → q_hit=1, q_data=0xB. With q_reg=0 → q_hit=0. Without the macro, q_hit=0.
- aresetn pulsed low with 3 entries queued → wr_en=0 and count=0 immediately. No further writes occur after release.
